sfx_voice_scheduler: RTL

Time-multiplexed sound-effect scheduler that feeds the I2S transmitter's stereo sample word. Up to NUM_SRC game events (shot, explosion, invader step, UFO) trigger one-shot sample playback from a shared sample ROM. On every sample request the block fetches one sample per active voice, mixes them with saturation, and presents the result as a `{left,right}` word. It sits between the game logic, the sample ROM and the I2S transmitter's `Tx` input.

---
 rtl/sfx_voice_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sfx_voice_scheduler.sv
// One-shot sample voice scheduler: fetches one ROM sample per active voice on
// each sample request, mixes with saturation and presents {mix,mix} to the I2S Tx.
module sfx_voice_scheduler #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        enable,
   input  logic [NUM_SRC-1:0]          trigger,
   input  logic [NUM_SRC*ADDR_W-1:0]   src_base,
   input  logic [NUM_SRC*ADDR_W-1:0]   src_len,
   input  logic                        sample_tick,
   output logic [ADDR_W-1:0]           rom_addr,
   output logic                        rom_rd,
   input  logic [WIDTH-1:0]            rom_data,
   output logic [2*WIDTH-1:0]          Tx,
   output logic                        tx_valid,
   output logic [NUM_SRC-1:0]          active,
   output logic                        overrun
);

   localparam int unsigned KW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned AW = WIDTH + $clog2(NUM_SRC) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_SRC - 1);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t state;

   logic [ADDR_W-1:0] base_q   [NUM_SRC];
   logic [ADDR_W-1:0] len_q    [NUM_SRC];
   logic [ADDR_W-1:0] ptr_q    [NUM_SRC];
   logic [ADDR_W-1:0] base_nxt [NUM_SRC];
   logic [ADDR_W-1:0] len_nxt  [NUM_SRC];
   logic [ADDR_W-1:0] ptr_nxt  [NUM_SRC];
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] act_nxt;
   logic [NUM_SRC-1:0] pend_nxt;

   logic [KW-1:0]          k;
   logic [KW-1:0]          k_nxt;
   logic                   rd_prev;
   logic signed [AW-1:0]   acc;
   logic signed [AW-1:0]   data_ext;
   logic [WIDTH-1:0]       mix;
   logic                   apply_ok;
   logic                   fetch_rd;
   logic [ADDR_W-1:0]      fetch_addr;

   // Next voice state: end-of-sample advance, pending apply (wins over end clear), enable flush
   always_comb begin
      apply_ok = (state == S_IDLE) || (state == S_OUT);
      act_nxt  = active;
      pend_nxt = '0;
      for (int unsigned v = 0; v < NUM_SRC; v++) begin
         base_nxt[v] = base_q[v];
         len_nxt[v]  = len_q[v];
         ptr_nxt[v]  = ptr_q[v];
         if ((state == S_OUT) && active[v]) begin
            ptr_nxt[v] = ADDR_W'(ptr_q[v] + 1'b1);
            if (ADDR_W'(ptr_q[v] + 1'b1) == len_q[v]) begin
               act_nxt[v] = 1'b0;
            end
         end
         if (apply_ok && pending[v]) begin
            base_nxt[v] = src_base[v*ADDR_W +: ADDR_W];
            len_nxt[v]  = src_len[v*ADDR_W +: ADDR_W];
            ptr_nxt[v]  = '0;
            act_nxt[v]  = 1'b1;
         end
         pend_nxt[v] = (pending[v] && !apply_ok)
                     || (trigger[v] && (src_len[v*ADDR_W +: ADDR_W] != '0));
      end
      if (!enable) begin
         act_nxt  = '0;
         pend_nxt = '0;
      end
   end

   // Read request for the voice the FSM visits next
   always_comb begin
      k_nxt      = (state == S_IDLE) ? '0 : KW'(k + 1'b1);
      fetch_rd   = act_nxt[k_nxt];
      fetch_addr = ADDR_W'(base_nxt[k_nxt] + ptr_nxt[k_nxt]);
   end

   always_comb begin
      data_ext = {{(AW-WIDTH){rom_data[WIDTH-1]}}, rom_data};
      if (acc > SAT_MAX) begin
         mix = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (acc < SAT_MIN) begin
         mix = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         mix = acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         k        <= '0;
         acc      <= '0;
         rd_prev  <= 1'b0;
         rom_rd   <= 1'b0;
         rom_addr <= '0;
         Tx       <= '0;
         tx_valid <= 1'b0;
         overrun  <= 1'b0;
         active   <= '0;
         pending  <= '0;
         for (int unsigned v = 0; v < NUM_SRC; v++) begin
            base_q[v] <= '0;
            len_q[v]  <= '0;
            ptr_q[v]  <= '0;
         end
      end else begin
         for (int unsigned v = 0; v < NUM_SRC; v++) begin
            base_q[v] <= base_nxt[v];
            len_q[v]  <= len_nxt[v];
            ptr_q[v]  <= ptr_nxt[v];
         end
         active   <= act_nxt;
         pending  <= pend_nxt;
         rd_prev  <= rom_rd;
         tx_valid <= 1'b0;
         overrun  <= 1'b0;
         rom_rd   <= 1'b0;
         rom_addr <= '0;

         case (state)
            S_IDLE: begin
               if (sample_tick) begin
                  state    <= S_FETCH;
                  k        <= '0;
                  acc      <= '0;
                  rom_rd   <= fetch_rd;
                  rom_addr <= fetch_addr;
               end
            end
            // Data returns one cycle after its read, so accumulation lags the read by one voice
            S_FETCH: begin
               overrun <= sample_tick;
               if (rd_prev) begin
                  acc <= acc + data_ext;
               end
               if (k == K_LAST) begin
                  state <= S_DRAIN;
               end else begin
                  k        <= k_nxt;
                  rom_rd   <= fetch_rd;
                  rom_addr <= fetch_addr;
               end
            end
            S_DRAIN: begin
               overrun <= sample_tick;
               if (rd_prev) begin
                  acc <= acc + data_ext;
               end
               state <= S_OUT;
            end
            S_OUT: begin
               overrun  <= sample_tick;
               Tx       <= enable ? {mix, mix} : '0;
               tx_valid <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
